// File: rtl/n101_qspi_pkg.sv
// Shared types for the QSPI link arbiter: FSM state codes, protocol codes
// and the bundle of controls one requester presents to the media link.
package n101_qspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] PROTO_SINGLE = 2'd0;
  localparam logic [1:0] PROTO_DUAL   = 2'd1;
  localparam logic [1:0] PROTO_QUAD   = 2'd2;

  // Everything a requester drives towards the media for one frame
  typedef struct packed {
    logic       tx_valid;
    logic [7:0] tx_bits;
    logic [7:0] cnt;
    logic [1:0] fmt_proto;
    logic       fmt_endian;
    logic       fmt_iodir;
    logic       cs_set;
    logic       cs_clear;
    logic       cs_hold;
  } link_req_t;

endpackage

// File: rtl/n101_qspi_link_mux.sv
// Combinational 2:1 link-bundle mux. When disabled every output is zero, so
// the media sees a quiet link and neither requester sees ready or rx data.
module n101_qspi_link_mux
  import n101_qspi_pkg::*;
(
  input  logic      en,
  input  logic      sel,
  input  link_req_t req0,
  input  link_req_t req1,
  input  logic      out_tx_ready,
  input  logic      out_rx_valid,
  output link_req_t out_req,
  output logic      tx_ready0,
  output logic      tx_ready1,
  output logic      rx_valid0,
  output logic      rx_valid1
);

  // Route the granted bundle to the media and the handshakes back to it only
  always_comb begin
    out_req   = '0;
    tx_ready0 = 1'b0;
    tx_ready1 = 1'b0;
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
    if (en) begin
      if (sel) begin
        out_req   = req1;
        tx_ready1 = out_tx_ready;
        rx_valid1 = out_rx_valid;
      end else begin
        out_req   = req0;
        tx_ready0 = out_tx_ready;
        rx_valid0 = out_rx_valid;
      end
    end
  end

endmodule

// File: rtl/n101_qspi_link_arbiter.sv
// Two-requester arbiter for the shared QSPI media link. A grant lasts a whole
// chip-select transaction, ends with a one-cycle release gap, and a watchdog
// reclaims a grant whose owner never starts a transaction.
module n101_qspi_link_arbiter
  import n101_qspi_pkg::*;
#(
  parameter int TMO_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_ctrl_prio,
  output logic       io_in_0_tx_ready,
  input  logic       io_in_0_tx_valid,
  input  logic [7:0] io_in_0_tx_bits,
  output logic       io_in_0_rx_valid,
  output logic [7:0] io_in_0_rx_bits,
  input  logic [7:0] io_in_0_cnt,
  input  logic [1:0] io_in_0_fmt_proto,
  input  logic       io_in_0_fmt_endian,
  input  logic       io_in_0_fmt_iodir,
  input  logic       io_in_0_cs_set,
  input  logic       io_in_0_cs_clear,
  input  logic       io_in_0_cs_hold,
  output logic       io_in_0_active,
  output logic       io_in_0_granted,
  output logic       io_in_1_tx_ready,
  input  logic       io_in_1_tx_valid,
  input  logic [7:0] io_in_1_tx_bits,
  output logic       io_in_1_rx_valid,
  output logic [7:0] io_in_1_rx_bits,
  input  logic [7:0] io_in_1_cnt,
  input  logic [1:0] io_in_1_fmt_proto,
  input  logic       io_in_1_fmt_endian,
  input  logic       io_in_1_fmt_iodir,
  input  logic       io_in_1_cs_set,
  input  logic       io_in_1_cs_clear,
  input  logic       io_in_1_cs_hold,
  output logic       io_in_1_active,
  output logic       io_in_1_granted,
  input  logic       io_out_tx_ready,
  output logic       io_out_tx_valid,
  output logic [7:0] io_out_tx_bits,
  input  logic       io_out_rx_valid,
  input  logic [7:0] io_out_rx_bits,
  output logic [7:0] io_out_cnt,
  output logic [1:0] io_out_fmt_proto,
  output logic       io_out_fmt_endian,
  output logic       io_out_fmt_iodir,
  output logic       io_out_cs_set,
  output logic       io_out_cs_clear,
  output logic       io_out_cs_hold,
  input  logic       io_out_active
);

  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             seen_act_q, seen_act_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  link_req_t req0, req1, out_req;
  logic [1:0] req_vec;
  logic       locked;
  logic       sel_tx_valid;
  logic [TMO_W-1:0] tmo_inc;

  assign req0 = '{tx_valid: io_in_0_tx_valid, tx_bits: io_in_0_tx_bits, cnt: io_in_0_cnt,
                  fmt_proto: io_in_0_fmt_proto, fmt_endian: io_in_0_fmt_endian,
                  fmt_iodir: io_in_0_fmt_iodir, cs_set: io_in_0_cs_set,
                  cs_clear: io_in_0_cs_clear, cs_hold: io_in_0_cs_hold};
  assign req1 = '{tx_valid: io_in_1_tx_valid, tx_bits: io_in_1_tx_bits, cnt: io_in_1_cnt,
                  fmt_proto: io_in_1_fmt_proto, fmt_endian: io_in_1_fmt_endian,
                  fmt_iodir: io_in_1_fmt_iodir, cs_set: io_in_1_cs_set,
                  cs_clear: io_in_1_cs_clear, cs_hold: io_in_1_cs_hold};

  assign req_vec      = {io_in_1_tx_valid, io_in_0_tx_valid};
  assign locked       = (state_q == ST_LOCK);
  assign sel_tx_valid = gnt_q ? io_in_1_tx_valid : io_in_0_tx_valid;
  assign tmo_inc      = tmo_q + TMO_ONE;

  n101_qspi_link_mux u_mux (
    .en           (locked),
    .sel          (gnt_q),
    .req0         (req0),
    .req1         (req1),
    .out_tx_ready (io_out_tx_ready),
    .out_rx_valid (io_out_rx_valid),
    .out_req      (out_req),
    .tx_ready0    (io_in_0_tx_ready),
    .tx_ready1    (io_in_1_tx_ready),
    .rx_valid0    (io_in_0_rx_valid),
    .rx_valid1    (io_in_1_rx_valid)
  );

  assign io_out_tx_valid   = out_req.tx_valid;
  assign io_out_tx_bits    = out_req.tx_bits;
  assign io_out_cnt        = out_req.cnt;
  assign io_out_fmt_proto  = out_req.fmt_proto;
  assign io_out_fmt_endian = out_req.fmt_endian;
  assign io_out_fmt_iodir  = out_req.fmt_iodir;
  assign io_out_cs_set     = out_req.cs_set;
  assign io_out_cs_clear   = out_req.cs_clear;
  assign io_out_cs_hold    = out_req.cs_hold;

  assign io_in_0_rx_bits = io_out_rx_bits;
  assign io_in_1_rx_bits = io_out_rx_bits;
  assign io_in_0_granted = locked && !gnt_q;
  assign io_in_1_granted = locked && gnt_q;
  assign io_in_0_active  = io_in_0_granted && io_out_active;
  assign io_in_1_active  = io_in_1_granted && io_out_active;

  // Next-state logic: arbitrate in IDLE, hold and watch the link in LOCK
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    seen_act_d = seen_act_q;
    tmo_d      = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (req_vec != 2'b00) begin
          gnt_d      = (!io_ctrl_prio && (&req_vec)) ? ~last_q : ~req_vec[0];
          state_d    = ST_LOCK;
          seen_act_d = 1'b0;
          tmo_d      = '0;
        end
      end
      ST_LOCK: begin
        if (seen_act_q) begin
          if (!io_out_active) state_d = ST_RELEASE;
        end else if (io_out_active) begin
          seen_act_d = 1'b1;
        end else if (sel_tx_valid) begin
          tmo_d = '0;
        end else begin
          tmo_d = tmo_inc;
          if (&tmo_inc) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; last starts at 1 so port 0 wins first
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      seen_act_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      seen_act_q <= seen_act_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_n101_qspi_link_arbiter.sv
// Self-checking bench for the QSPI link arbiter: directed scenarios followed
// by randomized traffic, all compared every cycle against a transaction-level
// reference model of who owns the link.
module tb_n101_qspi_link_arbiter;

  localparam int TMO_W   = 3;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic clock = 1'b0;
  logic reset;
  logic prio;
  logic       tx_valid [2];
  logic [7:0] tx_bits  [2];
  logic [7:0] cnt      [2];
  logic [1:0] proto    [2];
  logic       endian   [2];
  logic       iodir    [2];
  logic       cs_set   [2];
  logic       cs_clear [2];
  logic       cs_hold  [2];
  logic       tx_ready [2];
  logic       rx_valid [2];
  logic [7:0] rx_bits  [2];
  logic       active   [2];
  logic       granted  [2];
  logic       out_tx_ready, out_rx_valid, out_active;
  logic [7:0] out_rx_bits;
  logic       out_tx_valid, out_endian, out_iodir, out_cs_set, out_cs_clear, out_cs_hold;
  logic [7:0] out_tx_bits, out_cnt;
  logic [1:0] out_proto;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the link, whether we are in the post-transaction
  // gap, whether the owner's transaction has started, and idle cycles so far
  bit owned, in_gap, started, last_owner;
  int owner, idle_cycles;

  always #5 clock = ~clock;

  n101_qspi_link_arbiter #(.TMO_W(TMO_W)) dut (
    .clock(clock), .reset(reset), .io_ctrl_prio(prio),
    .io_in_0_tx_ready(tx_ready[0]), .io_in_0_tx_valid(tx_valid[0]), .io_in_0_tx_bits(tx_bits[0]),
    .io_in_0_rx_valid(rx_valid[0]), .io_in_0_rx_bits(rx_bits[0]), .io_in_0_cnt(cnt[0]),
    .io_in_0_fmt_proto(proto[0]), .io_in_0_fmt_endian(endian[0]), .io_in_0_fmt_iodir(iodir[0]),
    .io_in_0_cs_set(cs_set[0]), .io_in_0_cs_clear(cs_clear[0]), .io_in_0_cs_hold(cs_hold[0]),
    .io_in_0_active(active[0]), .io_in_0_granted(granted[0]),
    .io_in_1_tx_ready(tx_ready[1]), .io_in_1_tx_valid(tx_valid[1]), .io_in_1_tx_bits(tx_bits[1]),
    .io_in_1_rx_valid(rx_valid[1]), .io_in_1_rx_bits(rx_bits[1]), .io_in_1_cnt(cnt[1]),
    .io_in_1_fmt_proto(proto[1]), .io_in_1_fmt_endian(endian[1]), .io_in_1_fmt_iodir(iodir[1]),
    .io_in_1_cs_set(cs_set[1]), .io_in_1_cs_clear(cs_clear[1]), .io_in_1_cs_hold(cs_hold[1]),
    .io_in_1_active(active[1]), .io_in_1_granted(granted[1]),
    .io_out_tx_ready(out_tx_ready), .io_out_tx_valid(out_tx_valid), .io_out_tx_bits(out_tx_bits),
    .io_out_rx_valid(out_rx_valid), .io_out_rx_bits(out_rx_bits), .io_out_cnt(out_cnt),
    .io_out_fmt_proto(out_proto), .io_out_fmt_endian(out_endian), .io_out_fmt_iodir(out_iodir),
    .io_out_cs_set(out_cs_set), .io_out_cs_clear(out_cs_clear), .io_out_cs_hold(out_cs_hold),
    .io_out_active(out_active)
  );

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clearInputs();
    prio = 1'b0;
    out_tx_ready = 1'b0; out_rx_valid = 1'b0; out_rx_bits = 8'h00; out_active = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tx_valid[n] = 1'b0; tx_bits[n] = 8'h00; cnt[n] = 8'h00; proto[n] = 2'd0;
      endian[n] = 1'b0; iodir[n] = 1'b0; cs_set[n] = 1'b0; cs_clear[n] = 1'b0; cs_hold[n] = 1'b0;
    end
  endtask

  // Randomized inputs; req_pct sets how often each requester asks for the link
  task automatic applyStimulus(input int req_pct);
    for (int n = 0; n < 2; n++) begin
      tx_valid[n] = ($urandom_range(0, 99) < req_pct);
      tx_bits[n]  = 8'($urandom);
      cnt[n]      = 8'($urandom);
      proto[n]    = 2'($urandom_range(0, 2));
      endian[n]   = 1'($urandom);
      iodir[n]    = 1'($urandom);
      cs_set[n]   = 1'($urandom);
      cs_clear[n] = 1'($urandom);
      cs_hold[n]  = 1'($urandom);
    end
    out_tx_ready = 1'($urandom);
    out_rx_valid = 1'($urandom);
    out_rx_bits  = 8'($urandom);
    if ($urandom_range(0, 3) == 0) out_active = ~out_active;
    if ($urandom_range(0, 63) == 0) prio = ~prio;
    reset = ($urandom_range(0, 299) == 0);
  endtask

  // Expected outputs follow directly from link ownership and the live inputs
  task automatic compareModel();
    bit o0, o1;
    int s;
    o0 = owned && (owner == 0);
    o1 = owned && (owner == 1);
    s  = o1 ? 1 : 0;
    checkOutput("granted0", granted[0], o0);
    checkOutput("granted1", granted[1], o1);
    checkOutput("tx_ready0", tx_ready[0], o0 && out_tx_ready);
    checkOutput("tx_ready1", tx_ready[1], o1 && out_tx_ready);
    checkOutput("rx_valid0", rx_valid[0], o0 && out_rx_valid);
    checkOutput("rx_valid1", rx_valid[1], o1 && out_rx_valid);
    checkOutput("rx_bits0", rx_bits[0], out_rx_bits);
    checkOutput("rx_bits1", rx_bits[1], out_rx_bits);
    checkOutput("active0", active[0], o0 && out_active);
    checkOutput("active1", active[1], o1 && out_active);
    checkOutput("out_tx_valid", out_tx_valid, owned ? tx_valid[s] : 1'b0);
    checkOutput("out_tx_bits", out_tx_bits, owned ? tx_bits[s] : 8'h00);
    checkOutput("out_cnt", out_cnt, owned ? cnt[s] : 8'h00);
    checkOutput("out_proto", out_proto, owned ? proto[s] : 2'd0);
    checkOutput("out_endian", out_endian, owned ? endian[s] : 1'b0);
    checkOutput("out_iodir", out_iodir, owned ? iodir[s] : 1'b0);
    checkOutput("out_cs_set", out_cs_set, owned ? cs_set[s] : 1'b0);
    checkOutput("out_cs_clear", out_cs_clear, owned ? cs_clear[s] : 1'b0);
    checkOutput("out_cs_hold", out_cs_hold, owned ? cs_hold[s] : 1'b0);
  endtask

  // Advance the ownership model by one clock using the inputs present at the edge
  task automatic modelStep();
    if (reset) begin
      owned = 0; in_gap = 0; started = 0; idle_cycles = 0; last_owner = 1;
    end else if (in_gap) begin
      last_owner = (owner == 1);
      in_gap = 0;
    end else if (owned) begin
      if (started) begin
        if (!out_active) begin owned = 0; in_gap = 1; end
      end else if (out_active) begin
        started = 1;
      end else if (tx_valid[owner]) begin
        idle_cycles = 0;
      end else begin
        idle_cycles++;
        if (idle_cycles == TMO_MAX) begin owned = 0; in_gap = 1; end
      end
    end else if (tx_valid[0] || tx_valid[1]) begin
      if (tx_valid[0] && tx_valid[1]) owner = prio ? 0 : (last_owner ? 0 : 1);
      else owner = tx_valid[0] ? 0 : 1;
      owned = 1; started = 0; idle_cycles = 0;
    end
  endtask

  // One cycle: check at the current negedge, step the model at posedge
  task automatic tick();
    #1 compareModel();
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    owned = 0; in_gap = 0; started = 0; idle_cycles = 0; last_owner = 1; owner = 0;
    @(negedge clock);
    doReset();

    // First grant: one cycle of arbitration, then port 0 owns the link
    tx_valid[0] = 1'b1; tx_bits[0] = 8'h03; out_tx_ready = 1'b1;
    #1 checkOutput("idle_no_ready0", tx_ready[0], 1'b0);
    tick();
    #1 checkOutput("first_granted0", granted[0], 1'b1);
    checkOutput("first_tx_bits", out_tx_bits, 8'h03);
    checkOutput("first_ready0", tx_ready[0], 1'b1);
    checkOutput("first_ready1", tx_ready[1], 1'b0);
    out_tx_ready = 1'b0;
    #1 checkOutput("ready0_follows", tx_ready[0], 1'b0);
    out_active = 1'b1; tick(); tick();
    out_active = 1'b0; tx_valid[0] = 1'b0; tick();
    #1 checkOutput("release_granted0", granted[0], 1'b0);
    tick();

    // Round-robin with both requesting: port 0 first, gap, then port 1
    clearInputs(); doReset();
    tx_valid[0] = 1'b1; tx_valid[1] = 1'b1; tick();
    #1 checkOutput("rr_first_port0", granted[0], 1'b1);
    out_active = 1'b1; tick();
    out_active = 1'b0; tick();
    #1 checkOutput("rr_gap_tx_valid", out_tx_valid, 1'b0);
    checkOutput("rr_gap_granted1", granted[1], 1'b0);
    tick(); tick();
    #1 checkOutput("rr_second_port1", granted[1], 1'b1);

    // Port 1 owns the link: rx routing and control mux
    cnt[1] = 8'd8; proto[1] = 2'd2; cs_hold[1] = 1'b1;
    out_rx_valid = 1'b1; out_rx_bits = 8'hA5;
    #1 checkOutput("rx_valid1_a5", rx_valid[1], 1'b1);
    checkOutput("rx_bits1_a5", rx_bits[1], 8'hA5);
    checkOutput("rx_valid0_blocked", rx_valid[0], 1'b0);
    checkOutput("out_cnt_8", out_cnt, 8'd8);
    checkOutput("out_proto_quad", out_proto, 2'd2);
    checkOutput("out_cs_hold_1", out_cs_hold, 1'b1);
    out_rx_valid = 1'b0;
    out_active = 1'b1; tick();
    out_active = 1'b0; tick(); tick();

    // Fixed priority: port 0 wins every transaction while it keeps asking
    clearInputs(); doReset();
    prio = 1'b1; tx_valid[0] = 1'b1; tx_valid[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      #1 checkOutput("prio_port0_wins", granted[0], 1'b1);
      checkOutput("prio_port1_starves", granted[1], 1'b0);
      out_active = 1'b1; tick();
      out_active = 1'b0; tick();
      tick();
    end

    // Watchdog: idle grant released after TMO_MAX idle cycles; a pulse restarts it
    clearInputs(); doReset();
    tx_valid[0] = 1'b1; tick();
    tx_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput("wd_hold_pre", granted[0], 1'b1);
      tick();
    end
    tx_valid[0] = 1'b1; tick();
    tx_valid[0] = 1'b0;
    for (int c = 0; c < TMO_MAX; c++) begin
      #1 checkOutput("wd_hold_post", granted[0], 1'b1);
      tick();
    end
    #1 checkOutput("wd_released", granted[0], 1'b0);
    tick();

    // Reset in the middle of a locked transaction
    clearInputs(); doReset();
    tx_valid[1] = 1'b1; tick();
    out_active = 1'b1; tick();
    reset = 1'b1; tick();
    #1 checkOutput("mid_reset_granted1", granted[1], 1'b0);
    checkOutput("mid_reset_tx_valid", out_tx_valid, 1'b0);
    reset = 1'b0; out_active = 1'b0; tx_valid[0] = 1'b1; tick();
    #1 checkOutput("mid_reset_last_port0", granted[0], 1'b1);

    // Randomized traffic in phases of busy and sparse requesting
    clearInputs(); doReset();
    for (int ph = 0; ph < 30; ph++) begin
      int pct;
      pct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 50; c++) begin
        applyStimulus(pct);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on run time so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] run time bound exceeded");
  end

endmodule
